// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: default widths,
// the Null tag, enable levels and the ALU opcode encodings.
package alu_rs_pkg;

  localparam int DEF_ENTRIES = 8;
  localparam int DEF_IDX_W   = 3;
  localparam int DEF_TAG_W   = 4;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_OP_W    = 6;

  localparam logic [DEF_TAG_W-1:0] TAG_NULL = '0;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [DEF_OP_W-1:0] {
    OP_NOP  = 6'd0,
    OP_ADD  = 6'd1,
    OP_SUB  = 6'd2,
    OP_AND  = 6'd3,
    OP_OR   = 6'd4,
    OP_XOR  = 6'd5,
    OP_SLL  = 6'd6,
    OP_SRL  = 6'd7,
    OP_SRA  = 6'd8,
    OP_SLT  = 6'd9,
    OP_SLTU = 6'd10,
    OP_ADDI = 6'd11,
    OP_ANDI = 6'd12,
    OP_ORI  = 6'd13,
    OP_XORI = 6'd14,
    OP_BEQ  = 6'd15,
    OP_BNE  = 6'd16,
    OP_LUI  = 6'd17,
    OP_AUIPC = 6'd18,
    OP_JAL  = 6'd19,
    OP_JALR = 6'd20
  } alu_op_e;

endpackage

// File: rtl/alu_rs_sel.sv
// Lowest-index priority encoder: reports whether any request bit is set
// and the index of the lowest one.
module alu_rs_sel #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: holds dispatched instructions,
// snoops the ALU and LSB CDBs for operands, and issues the lowest ready slot.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int IDX_W   = DEF_IDX_W,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int OP_W    = DEF_OP_W
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              clear_i,
  input  logic              disp_en_i,
  input  logic [OP_W-1:0]   disp_op_i,
  input  logic [DATA_W-1:0] disp_vj_i,
  input  logic [DATA_W-1:0] disp_vk_i,
  input  logic [TAG_W-1:0]  disp_qj_i,
  input  logic [TAG_W-1:0]  disp_qk_i,
  input  logic [DATA_W-1:0] disp_imm_i,
  input  logic [DATA_W-1:0] disp_pc_i,
  input  logic [TAG_W-1:0]  disp_des_i,
  output logic              rs_full_o,
  input  logic              cdb_alu_en_i,
  input  logic [TAG_W-1:0]  cdb_alu_tag_i,
  input  logic [DATA_W-1:0] cdb_alu_data_i,
  input  logic              cdb_lsb_en_i,
  input  logic [TAG_W-1:0]  cdb_lsb_tag_i,
  input  logic [DATA_W-1:0] cdb_lsb_data_i,
  output logic              alu_en_o,
  output logic [OP_W-1:0]   alu_op_o,
  output logic [DATA_W-1:0] alu_reg1_o,
  output logic [DATA_W-1:0] alu_reg2_o,
  output logic [DATA_W-1:0] alu_imm_o,
  output logic [DATA_W-1:0] alu_pc_o,
  output logic [TAG_W-1:0]  alu_des_o
);

  localparam logic [IDX_W:0] FULL_LVL = (IDX_W + 1)'(ENTRIES - 1);

  logic [ENTRIES-1:0] busy;
  logic [OP_W-1:0]    op_q  [ENTRIES];
  logic [DATA_W-1:0]  vj_q  [ENTRIES];
  logic [DATA_W-1:0]  vk_q  [ENTRIES];
  logic [TAG_W-1:0]   qj_q  [ENTRIES];
  logic [TAG_W-1:0]   qk_q  [ENTRIES];
  logic [DATA_W-1:0]  imm_q [ENTRIES];
  logic [DATA_W-1:0]  pc_q  [ENTRIES];
  logic [TAG_W-1:0]   des_q [ENTRIES];

  logic               wake_j      [ENTRIES];
  logic               wake_k      [ENTRIES];
  logic [DATA_W-1:0]  wake_j_data [ENTRIES];
  logic [DATA_W-1:0]  wake_k_data [ENTRIES];
  logic [ENTRIES-1:0] ready_vec;
  logic [ENTRIES-1:0] free_vec;

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             ready_found;
  logic [IDX_W-1:0] ready_idx;
  logic             disp_fire;

  logic              disp_j_alu, disp_j_lsb, disp_k_alu, disp_k_lsb;
  logic [DATA_W-1:0] disp_vj_res, disp_vk_res;
  logic [TAG_W-1:0]  disp_qj_res, disp_qk_res;

  logic [IDX_W:0] busy_cnt;
  logic [IDX_W:0] cnt_next;

  // Per-slot CDB snoop; a slot whose operand is already resolved never matches.
  for (genvar g = 0; g < ENTRIES; g++) begin : g_wake
    assign wake_j[g] = (qj_q[g] != '0) &&
                       ((cdb_alu_en_i && cdb_alu_tag_i == qj_q[g]) ||
                        (cdb_lsb_en_i && cdb_lsb_tag_i == qj_q[g]));
    assign wake_k[g] = (qk_q[g] != '0) &&
                       ((cdb_alu_en_i && cdb_alu_tag_i == qk_q[g]) ||
                        (cdb_lsb_en_i && cdb_lsb_tag_i == qk_q[g]));
    assign wake_j_data[g] = (cdb_alu_en_i && cdb_alu_tag_i == qj_q[g]) ?
                            cdb_alu_data_i : cdb_lsb_data_i;
    assign wake_k_data[g] = (cdb_alu_en_i && cdb_alu_tag_i == qk_q[g]) ?
                            cdb_alu_data_i : cdb_lsb_data_i;
    assign ready_vec[g] = busy[g] && (qj_q[g] == '0) && (qk_q[g] == '0);
  end

  assign free_vec = ~busy;

  alu_rs_sel #(.N(ENTRIES), .W(IDX_W)) u_free_sel (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  alu_rs_sel #(.N(ENTRIES), .W(IDX_W)) u_ready_sel (
    .req   (ready_vec),
    .found (ready_found),
    .idx   (ready_idx)
  );

  assign disp_fire  = disp_en_i && free_found;
  assign disp_j_alu = (disp_qj_i != '0) && cdb_alu_en_i && (cdb_alu_tag_i == disp_qj_i);
  assign disp_j_lsb = (disp_qj_i != '0) && cdb_lsb_en_i && (cdb_lsb_tag_i == disp_qj_i);
  assign disp_k_alu = (disp_qk_i != '0) && cdb_alu_en_i && (cdb_alu_tag_i == disp_qk_i);
  assign disp_k_lsb = (disp_qk_i != '0) && cdb_lsb_en_i && (cdb_lsb_tag_i == disp_qk_i);

  // A source produced on a CDB in the dispatch cycle is captured directly.
  always_comb begin
    disp_vj_res = disp_vj_i;
    disp_qj_res = disp_qj_i;
    disp_vk_res = disp_vk_i;
    disp_qk_res = disp_qk_i;
    if (disp_j_alu) begin
      disp_vj_res = cdb_alu_data_i;
      disp_qj_res = '0;
    end else if (disp_j_lsb) begin
      disp_vj_res = cdb_lsb_data_i;
      disp_qj_res = '0;
    end
    if (disp_k_alu) begin
      disp_vk_res = cdb_alu_data_i;
      disp_qk_res = '0;
    end else if (disp_k_lsb) begin
      disp_vk_res = cdb_lsb_data_i;
      disp_qk_res = '0;
    end
  end

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      busy_cnt = busy_cnt + (IDX_W + 1)'(busy[i]);
    end
    cnt_next = busy_cnt - (IDX_W + 1)'(ready_found) + (IDX_W + 1)'(disp_fire);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy       <= '0;
      rs_full_o  <= 1'b0;
      alu_en_o   <= 1'b0;
      alu_op_o   <= '0;
      alu_reg1_o <= '0;
      alu_reg2_o <= '0;
      alu_imm_o  <= '0;
      alu_pc_o   <= '0;
      alu_des_o  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i]  <= '0;
        vj_q[i]  <= '0;
        vk_q[i]  <= '0;
        qj_q[i]  <= '0;
        qk_q[i]  <= '0;
        imm_q[i] <= '0;
        pc_q[i]  <= '0;
        des_q[i] <= '0;
      end
    end else if (clear_i) begin
      busy      <= '0;
      alu_en_o  <= 1'b0;
      rs_full_o <= 1'b0;
    end else if (!rdy_in) begin
      alu_en_o <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (busy[i]) begin
          if (wake_j[i]) begin
            vj_q[i] <= wake_j_data[i];
            qj_q[i] <= '0;
          end
          if (wake_k[i]) begin
            vk_q[i] <= wake_k_data[i];
            qk_q[i] <= '0;
          end
        end
      end

      alu_en_o <= ready_found;
      if (ready_found) begin
        alu_op_o        <= op_q[ready_idx];
        alu_reg1_o      <= vj_q[ready_idx];
        alu_reg2_o      <= vk_q[ready_idx];
        alu_imm_o       <= imm_q[ready_idx];
        alu_pc_o        <= pc_q[ready_idx];
        alu_des_o       <= des_q[ready_idx];
        busy[ready_idx] <= 1'b0;
      end

      // The free slot comes from the pre-edge busy vector, so it never
      // collides with the slot being issued this edge.
      if (disp_fire) begin
        busy[free_idx]  <= 1'b1;
        op_q[free_idx]  <= disp_op_i;
        vj_q[free_idx]  <= disp_vj_res;
        qj_q[free_idx]  <= disp_qj_res;
        vk_q[free_idx]  <= disp_vk_res;
        qk_q[free_idx]  <= disp_qk_res;
        imm_q[free_idx] <= disp_imm_i;
        pc_q[free_idx]  <= disp_pc_i;
        des_q[free_idx] <= disp_des_i;
      end

      rs_full_o <= (cnt_next >= FULL_LVL);
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: a slot-level reference model predicts each
// issue bundle and its cycle; a negedge monitor pops and compares.
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int ENTRIES = 8;
  localparam int TAG_W   = 4;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 6;

  logic              clk_in, rst_n_in, rdy_in, clear_i, disp_en_i;
  logic [OP_W-1:0]   disp_op_i;
  logic [DATA_W-1:0] disp_vj_i, disp_vk_i, disp_imm_i, disp_pc_i;
  logic [TAG_W-1:0]  disp_qj_i, disp_qk_i, disp_des_i;
  logic              rs_full_o;
  logic              cdb_alu_en_i, cdb_lsb_en_i;
  logic [TAG_W-1:0]  cdb_alu_tag_i, cdb_lsb_tag_i;
  logic [DATA_W-1:0] cdb_alu_data_i, cdb_lsb_data_i;
  logic              alu_en_o;
  logic [OP_W-1:0]   alu_op_o;
  logic [DATA_W-1:0] alu_reg1_o, alu_reg2_o, alu_imm_o, alu_pc_o;
  logic [TAG_W-1:0]  alu_des_o;

  alu_rs dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_i(clear_i),
    .disp_en_i(disp_en_i), .disp_op_i(disp_op_i),
    .disp_vj_i(disp_vj_i), .disp_vk_i(disp_vk_i),
    .disp_qj_i(disp_qj_i), .disp_qk_i(disp_qk_i),
    .disp_imm_i(disp_imm_i), .disp_pc_i(disp_pc_i), .disp_des_i(disp_des_i),
    .rs_full_o(rs_full_o),
    .cdb_alu_en_i(cdb_alu_en_i), .cdb_alu_tag_i(cdb_alu_tag_i), .cdb_alu_data_i(cdb_alu_data_i),
    .cdb_lsb_en_i(cdb_lsb_en_i), .cdb_lsb_tag_i(cdb_lsb_tag_i), .cdb_lsb_data_i(cdb_lsb_data_i),
    .alu_en_o(alu_en_o), .alu_op_o(alu_op_o),
    .alu_reg1_o(alu_reg1_o), .alu_reg2_o(alu_reg2_o),
    .alu_imm_o(alu_imm_o), .alu_pc_o(alu_pc_o), .alu_des_o(alu_des_o)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    int                cyc;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] r1, r2, imm, pc;
    logic [TAG_W-1:0]  des;
  } exp_t;

  typedef struct {
    bit                busy;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] vj, vk, imm, pc;
    logic [TAG_W-1:0]  qj, qk, des;
  } slot_t;

  exp_t  sb[$];
  slot_t slots[ENTRIES];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  logic  exp_full = 1'b0;
  logic  exp_full_next = 1'b0;

  always @(posedge clk_in) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int freeSlots();
    int n = 0;
    for (int i = 0; i < ENTRIES; i++) if (!slots[i].busy) n++;
    return n;
  endfunction

  // Resolve a source against this cycle's broadcasts: returns 1 and the data on a hit.
  function automatic logic cdbHit(input logic [TAG_W-1:0] q, output logic [DATA_W-1:0] d);
    d = '0;
    if (q == TAG_NULL) return 1'b0;
    if (cdb_alu_en_i && cdb_alu_tag_i == q) begin d = cdb_alu_data_i; return 1'b1; end
    if (cdb_lsb_en_i && cdb_lsb_tag_i == q) begin d = cdb_lsb_data_i; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic modelStep();
    int rsel = -1;
    int fsel = -1;
    int cnt  = 0;
    logic [DATA_W-1:0] d;
    exp_t e;
    if (clear_i) begin
      for (int i = 0; i < ENTRIES; i++) slots[i].busy = 0;
      exp_full_next = 1'b0;
      return;
    end
    if (!rdy_in) begin
      exp_full_next = exp_full;
      return;
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (slots[i].busy && slots[i].qj == TAG_NULL && slots[i].qk == TAG_NULL) rsel = i;
      if (!slots[i].busy) fsel = i;
    end
    if (rsel >= 0) begin
      e.cyc = cyc + 1;
      e.op = slots[rsel].op;   e.r1 = slots[rsel].vj; e.r2 = slots[rsel].vk;
      e.imm = slots[rsel].imm; e.pc = slots[rsel].pc; e.des = slots[rsel].des;
      sb.push_back(e);
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (slots[i].busy && cdbHit(slots[i].qj, d)) begin slots[i].vj = d; slots[i].qj = TAG_NULL; end
      if (slots[i].busy && cdbHit(slots[i].qk, d)) begin slots[i].vk = d; slots[i].qk = TAG_NULL; end
    end
    if (rsel >= 0) slots[rsel].busy = 0;
    if (disp_en_i) begin
      assert (fsel >= 0) else $error("[TB] dispatch into a full station");
      if (fsel >= 0) begin
        slots[fsel].busy = 1;
        slots[fsel].op = disp_op_i; slots[fsel].imm = disp_imm_i;
        slots[fsel].pc = disp_pc_i; slots[fsel].des = disp_des_i;
        slots[fsel].vj = disp_vj_i; slots[fsel].qj = disp_qj_i;
        slots[fsel].vk = disp_vk_i; slots[fsel].qk = disp_qk_i;
        if (cdbHit(disp_qj_i, d)) begin slots[fsel].vj = d; slots[fsel].qj = TAG_NULL; end
        if (cdbHit(disp_qk_i, d)) begin slots[fsel].vk = d; slots[fsel].qk = TAG_NULL; end
      end
    end
    for (int i = 0; i < ENTRIES; i++) if (slots[i].busy) cnt++;
    exp_full_next = (cnt >= ENTRIES - 1);
  endtask

  task automatic setIdle();
    rdy_in = 1'b1; clear_i = 1'b0; disp_en_i = 1'b0;
    disp_op_i = '0; disp_vj_i = '0; disp_vk_i = '0; disp_qj_i = '0; disp_qk_i = '0;
    disp_imm_i = '0; disp_pc_i = '0; disp_des_i = '0;
    cdb_alu_en_i = 1'b0; cdb_alu_tag_i = '0; cdb_alu_data_i = '0;
    cdb_lsb_en_i = 1'b0; cdb_lsb_tag_i = '0; cdb_lsb_data_i = '0;
  endtask

  task automatic dispatch(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] vj,
                          input logic [TAG_W-1:0] qj, input logic [DATA_W-1:0] vk,
                          input logic [TAG_W-1:0] qk, input logic [DATA_W-1:0] imm,
                          input logic [DATA_W-1:0] pc, input logic [TAG_W-1:0] des);
    disp_en_i = 1'b1; disp_op_i = op; disp_vj_i = vj; disp_qj_i = qj;
    disp_vk_i = vk; disp_qk_i = qk; disp_imm_i = imm; disp_pc_i = pc; disp_des_i = des;
  endtask

  task automatic cdbAlu(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    cdb_alu_en_i = 1'b1; cdb_alu_tag_i = t; cdb_alu_data_i = d;
  endtask

  task automatic cdbLsb(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    cdb_lsb_en_i = 1'b1; cdb_lsb_tag_i = t; cdb_lsb_data_i = d;
  endtask

  task automatic applyStimulus();
    modelStep();
    @(posedge clk_in);
    #1;
    exp_full = exp_full_next;
    setIdle();
  endtask

  task automatic modelReset();
    for (int i = 0; i < ENTRIES; i++) slots[i].busy = 0;
    sb.delete();
    exp_full = 1'b0;
    exp_full_next = 1'b0;
  endtask

  // Monitor: every cycle compares rs_full, and the issue bundle whenever one is due or seen.
  always @(negedge clk_in) begin
    exp_t e;
    logic due;
    if (rst_n_in) begin
      checkOutput("rs_full", {63'd0, rs_full_o}, {63'd0, exp_full});
      due = (sb.size() > 0) && (sb[0].cyc == cyc);
      checkOutput("alu_en", {63'd0, alu_en_o}, {63'd0, due});
      if (due) begin
        e = sb.pop_front();
        if (alu_en_o) begin
          checkOutput("alu_op",   64'(alu_op_o),   64'(e.op));
          checkOutput("alu_reg1", 64'(alu_reg1_o), 64'(e.r1));
          checkOutput("alu_reg2", 64'(alu_reg2_o), 64'(e.r2));
          checkOutput("alu_imm",  64'(alu_imm_o),  64'(e.imm));
          checkOutput("alu_pc",   64'(alu_pc_o),   64'(e.pc));
          checkOutput("alu_des",  64'(alu_des_o),  64'(e.des));
        end
      end
    end
  end

  initial begin
    logic [TAG_W-1:0] t1;
    setIdle();
    modelReset();
    rst_n_in = 1'b0;
    #2;
    checkOutput("reset_alu_en",  {63'd0, alu_en_o},  64'd0);
    checkOutput("reset_rs_full", {63'd0, rs_full_o}, 64'd0);
    checkOutput("reset_reg1",    64'(alu_reg1_o),    64'd0);
    checkOutput("reset_des",     64'(alu_des_o),     64'd0);
    #10;
    rst_n_in = 1'b1;

    // Ready ADD issues one cycle after dispatch.
    dispatch(OP_ADD, 32'd5, 4'd0, 32'd7, 4'd0, 32'd0, 32'h1000, 4'd3);
    applyStimulus();
    applyStimulus();
    checkOutput("add_issue_reg1", 64'(alu_reg1_o), 64'd5);
    checkOutput("add_issue_reg2", 64'(alu_reg2_o), 64'd7);
    applyStimulus();

    // ADDI waiting on tag 2, woken from the LSB CDB.
    dispatch(OP_ADDI, 32'hDEAD, 4'd2, 32'd0, 4'd0, 32'd10, 32'h1004, 4'd4);
    applyStimulus();
    applyStimulus();
    cdbLsb(4'd2, 32'h20);
    applyStimulus();
    applyStimulus();
    checkOutput("addi_wake_reg1", 64'(alu_reg1_o), 64'h20);
    applyStimulus();

    // Same-cycle bypass of qk from the ALU CDB.
    dispatch(OP_SUB, 32'd1, 4'd0, 32'd0, 4'd6, 32'd0, 32'h1008, 4'd5);
    cdbAlu(4'd6, 32'hFF);
    applyStimulus();
    applyStimulus();
    checkOutput("bypass_reg2", 64'(alu_reg2_o), 64'hFF);
    applyStimulus();

    // Fill seven dependent slots, then release them with one broadcast.
    for (int i = 0; i < 7; i++) begin
      dispatch(OP_XOR, 32'd0, 4'd9, 32'(i * 3), 4'd0, 32'(i), 32'h2000 + 32'(4 * i), 4'(i + 1));
      applyStimulus();
    end
    checkOutput("fill_full", {63'd0, rs_full_o}, 64'd1);
    cdbAlu(4'd9, 32'h99);
    applyStimulus();
    applyStimulus();
    checkOutput("fill_first_des", 64'(alu_des_o), 64'd1);
    checkOutput("fill_full_drop", {63'd0, rs_full_o}, 64'd0);
    for (int i = 0; i < 8; i++) applyStimulus();

    // Flush with simultaneous dispatch and broadcast.
    for (int i = 0; i < 3; i++) begin
      dispatch(OP_OR, 32'd0, 4'd5, 32'd0, 4'd0, 32'd0, 32'h3000, 4'(10 + i));
      applyStimulus();
    end
    clear_i = 1'b1;
    dispatch(OP_AND, 32'd1, 4'd0, 32'd2, 4'd0, 32'd0, 32'h3010, 4'd13);
    cdbAlu(4'd5, 32'h55);
    applyStimulus();
    checkOutput("clear_alu_en",  {63'd0, alu_en_o},  64'd0);
    checkOutput("clear_rs_full", {63'd0, rs_full_o}, 64'd0);
    cdbAlu(4'd5, 32'h55);
    applyStimulus();
    for (int i = 0; i < 3; i++) applyStimulus();

    // Stall a ready entry with rdy_in low.
    dispatch(OP_SLT, 32'd11, 4'd0, 32'd22, 4'd0, 32'd0, 32'h4000, 4'd7);
    applyStimulus();
    for (int i = 0; i < 3; i++) begin
      rdy_in = 1'b0;
      applyStimulus();
      checkOutput("stall_alu_en", {63'd0, alu_en_o}, 64'd0);
    end
    applyStimulus();
    checkOutput("stall_release_reg1", 64'(alu_reg1_o), 64'd11);

    // Asynchronous reset while an issue is being presented.
    dispatch(OP_ADD, 32'h77, 4'd0, 32'h88, 4'd0, 32'd0, 32'h5000, 4'd8);
    applyStimulus();
    applyStimulus();
    checkOutput("pre_reset_alu_en", {63'd0, alu_en_o}, 64'd1);
    #1;
    rst_n_in = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset_alu_en", {63'd0, alu_en_o}, 64'd0);
    checkOutput("async_reset_reg1",   64'(alu_reg1_o),   64'd0);
    checkOutput("async_reset_pc",     64'(alu_pc_o),     64'd0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      rdy_in  = ($urandom_range(0, 7) != 0);
      clear_i = ($urandom_range(0, 49) == 0);
      if (freeSlots() > 0 && $urandom_range(0, 1) == 1)
        dispatch(6'($urandom_range(1, 20)), $urandom,
                 ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                 $urandom,
                 ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                 $urandom, $urandom, 4'($urandom_range(0, 15)));
      t1 = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 1) cdbAlu(t1, $urandom);
      if ($urandom_range(0, 1) == 1) cdbLsb((t1 == 4'd15) ? 4'd1 : t1 + 4'd1, $urandom);
      applyStimulus();
    end

    // Drain: broadcast every tag so pending entries resolve and issue.
    for (int t = 1; t < 16; t++) begin
      cdbAlu(4'(t), 32'(t * 16));
      applyStimulus();
    end
    for (int i = 0; i < 10; i++) applyStimulus();
    @(negedge clk_in);
    #1;
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station and issue scheduler for the combinational integer ALU.
- Holds up to ENTRIES dispatched ALU instructions and snoops both CDBs (ALU, LSB) to resolve pending source tags.
- Each cycle, issues the lowest-index ready entry to the ALU through a registered operand bundle.
- Sits between the dispatcher and the ALU; flushed on branch misprediction.

Parameters:
ENTRIES, 8, number of RS slots (power of two, >=2)
IDX_W, 3, log2(ENTRIES)
TAG_W, 4, ROB tag width; tag 0 means "no dependency / Null"
DATA_W, 32, operand width
OP_W, 6, internal opcode width

Ports:
clk_in  in  1  clock
rst_n_in  in  1  asynchronous active-low reset
rdy_in  in  1  global ready; 0 freezes all state
clear_i  in  1  flush all entries (mispredict)
disp_en_i  in  1  dispatch valid
disp_op_i  in  OP_W  opcode
disp_vj_i / disp_vk_i  in  DATA_W  source values (valid when matching q is 0)
disp_qj_i / disp_qk_i  in  TAG_W  pending source tags
disp_imm_i  in  DATA_W  immediate
disp_pc_i  in  DATA_W  instruction PC
disp_des_i  in  TAG_W  destination ROB tag
rs_full_o  out  1  registered almost-full
cdb_alu_en_i / cdb_lsb_en_i  in  1  CDB broadcast valid
cdb_alu_tag_i / cdb_lsb_tag_i  in  TAG_W  broadcast tag
cdb_alu_data_i / cdb_lsb_data_i  in  DATA_W  broadcast data
alu_en_o  out  1  issue valid to ALU
alu_op_o  out  OP_W  opcode
alu_reg1_o / alu_reg2_o  out  DATA_W  operands
alu_imm_o  out  DATA_W  immediate
alu_pc_o  out  DATA_W  PC
alu_des_o  out  TAG_W  destination tag

Behaviour:
- Reset (async, rst_n_in=0): all busy bits 0; rs_full_o=0; alu_en_o=0; all alu_* data outputs 0.
- Entry fields: busy, op, vj, qj, vk, qk, imm, pc, des.
- Priority per rising edge: reset > clear_i > rdy_in=0 > normal operation.
- clear_i=1: all busy bits 0, alu_en_o=0, rs_full_o=0. Dispatch and CDB in the same cycle are ignored.
- rdy_in=0: no entry changes; alu_en_o forced 0 next edge so the ALU does not re-fire.
- Wakeup: for each busy entry, if qj!=0 and an enabled CDB tag equals qj, then vj<=data and qj<=0. Same for qk.
  - Both CDBs are checked. Tags are unique, so a double match cannot occur.
- Dispatch: on disp_en_i, write the lowest-index non-busy slot, chosen from the busy vector at the start of the cycle.
  - Same-cycle bypass: if disp_qj_i/disp_qk_i matches an enabled CDB tag, store the CDB data with q=0.
- Issue select (combinational): lowest-index entry with busy=1, qj=0, qk=0, evaluated on registered entry state.
  - Next edge: alu_en_o<=1, alu_* <= entry fields with reg1=vj, reg2=vk; that entry's busy<=0.
  - If no entry is ready: alu_en_o<=0; data outputs hold their last values.
- Latency:
  - Dispatch with ready operands at edge t; issued (alu_en_o=1) after edge t+1.
  - Entry woken by a CDB at edge t; issued after edge t+1.
  - The ALU result appears on CDB combinationally in the cycle alu_en_o=1.
- Slot freed at issue is not reusable in that same edge (allocation uses the pre-edge busy vector). Issue and dispatch in the same cycle are both legal.
- rs_full_o <= (busy count after this edge) >= ENTRIES-1. This gives one cycle of slack for a dispatch already in flight.
- Dispatch with no free slot is a protocol violation: the instruction is dropped, and the bench asserts on it.
- An entry with qj=0 ignores CDB traffic; op/des are never modified after dispatch.

Decomposition:
- Shared definitions file (existing global header): TAG_W/DATA_W/OP_W bus macros, Null=0, Enable/Disable, opcode encodings.
- Natural sub-module: alu_rs_sel, a priority encoder returning {found, index}. Instantiated twice: lowest free slot (on ~busy) and lowest ready slot.
- Wakeup compare is inline per entry (generate loop).

Test Plan:
- Reset, dispatch ADD with qj=0,vj=5, qk=0,vk=7, des=3 -> one cycle later alu_en_o=1, reg1=5, reg2=7, des=3; next cycle alu_en_o=0.
- Dispatch ADDI qj=2 (vj=x), imm=10, des=4; two cycles later cdb_lsb_en=1 tag=2 data=0x20 -> alu_en_o=1 with reg1=0x20 after the following edge.
- Dispatch with qk=6 in the same cycle that cdb_alu tag=6 data=0xFF -> stored vk=0xFF, issued next cycle.
- Dispatch 7 dependent entries (qj=9) -> rs_full_o=1 after the 7th. Broadcast tag 9 -> entries issue one per cycle in index order 0..6; rs_full_o drops after the first issue.
- Three entries pending, clear_i=1 with a simultaneous dispatch and CDB -> all busy 0, alu_en_o=0, rs_full_o=0; no issue afterwards.
- Ready entry with rdy_in=0 for 3 cycles -> alu_en_o stays 0; rdy_in=1 -> issued next edge. Assert rst_n_in mid-operation -> outputs are 0 immediately, without waiting for a clock.
